freq_meter: RTL and testbench

Gated-count frequency meter for the watch design. Measures the frequency of an external or internally divided signal by counting its rising edges over a fixed gate window of CLOCK cycles (default 1 s at 50 MHz), which is the inverse of a clock divider. The result goes to the display/self-test path for checking divider outputs and external inputs. Single clock domain; `sig_in` is the only asynchronous input.

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/freq_meter_sync_edge_det.sv | 37 +++
 rtl/freq_meter.sv | 140 ++++++++++++++
 tb/tb_freq_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated-count frequency meter.
package freq_meter_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // One-second gate at 50 MHz.
  localparam int GATE_1S   = 50_000_000;
  localparam int CNT_W_DEF = 32;

endpackage : freq_meter_pkg

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Any asynchronous level input (signal under test, buttons) can use this.
module sync_edge_det (
  input  logic CLOCK,
  input  logic RESET,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q,   dly_d;

  // Next-state for the synchronizer chain and the delay flop.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  // Synchronizer and delay registers; falling-edge clocked like the rest of the watch.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  // Edge pulse is high for the one cycle where the synchronized level has just risen.
  assign rise_pulse = sync2_q & ~dly_q;

endmodule : sync_edge_det

// File: rtl/freq_meter.sv
// Gated-count frequency meter: counts rising edges of sig_in over a window
// of GATE_CYCLES clock cycles and reports the count with a one-cycle valid.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             edge_s;

  sync_edge_det u_sync_edge_det (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .async_in   (sig_in),
    .rise_pulse (edge_s)
  );

  // Sequencer next-state, counters and result capture.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    freq_d       = freq_q;
    overflow_d   = overflow_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_sticky_d = 1'b0;
          state_d      = ST_MEASURE;
          busy_d       = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_MEASURE: begin
        busy_d     = 1'b1;
        gate_cnt_d = gate_cnt_q + GATE_ONE;
        if (edge_s) begin
          // Saturate rather than wrap; an edge lost at the ceiling is remembered.
          if (edge_cnt_q == CNT_MAX) begin
            ovf_sticky_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_ONE;
          end
        end else begin
          edge_cnt_d = edge_cnt_q;
        end
        // Last gate cycle: its edge is included, and the result is registered
        // so it is visible during the DONE cycle together with valid.
        if (gate_cnt_q == GATE_LAST) begin
          state_d    = ST_DONE;
          freq_d     = edge_cnt_d;
          overflow_d = ovf_sticky_d;
          valid_d    = 1'b1;
        end else begin
          state_d = ST_MEASURE;
        end
      end

      ST_DONE: begin
        if (continuous) begin
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_sticky_d = 1'b0;
          state_d      = ST_MEASURE;
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      freq_q       <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      freq_q       <= freq_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule : freq_meter

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit and a 4-bit instance share
// clock, reset, sig_in and controls; both use a 100-cycle gate.
module tb_freq_meter;

  localparam int GATE = 100;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        busy_a, valid_a, overflow_a;
  logic [31:0] freq_a;
  logic        busy_b, valid_b, overflow_b;
  logic [3:0]  freq_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus waveform control: period 0 means hold sig_lvl.
  int sig_per = 0;
  bit sig_lvl = 1'b0;
  int sig_ph  = 0;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy_a), .freq(freq_a),
    .valid(valid_a), .overflow(overflow_a)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy_b), .freq(freq_b),
    .valid(valid_b), .overflow(overflow_b)
  );

  always #5 CLOCK = ~CLOCK;

  // Signal under test changes on the rising edge, away from the DUT's active edge.
  always @(posedge CLOCK) begin
    if (sig_per == 0) begin
      sig_in = sig_lvl;
    end else begin
      sig_ph = (sig_ph + 1) % sig_per;
      sig_in = (sig_ph < sig_per / 2);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; on return cyc = 1 (first MEASURE cycle).
  task automatic do_start(output int cyc);
    @(posedge CLOCK);
    start = 1'b1;
    @(posedge CLOCK);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic advance_to(inout int cyc, input int target);
    while (cyc < target) begin
      @(posedge CLOCK);
      cyc++;
    end
  endtask

  // Step until valid_a is seen (bounded); cyc ends at the valid cycle.
  task automatic wait_valid(inout int cyc);
    while (!valid_a && cyc < 400) begin
      @(posedge CLOCK);
      cyc++;
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge CLOCK);
      if (valid_a || valid_b) cnt++;
    end
  endtask

  typedef struct {
    int per;
    bit lvl;
    int exp_a;
    int exp_b;
    bit ovf_b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    int cnt;

    vecs[0] = '{per: 10, lvl: 1'b0, exp_a: 10, exp_b: 10, ovf_b: 1'b0};
    vecs[1] = '{per: 0,  lvl: 1'b1, exp_a: 0,  exp_b: 0,  ovf_b: 1'b0};
    vecs[2] = '{per: 4,  lvl: 1'b0, exp_a: 25, exp_b: 15, ovf_b: 1'b1};
    vecs[3] = '{per: 0,  lvl: 1'b1, exp_a: 0,  exp_b: 0,  ovf_b: 1'b0};
    vecs[4] = '{per: 20, lvl: 1'b0, exp_a: 5,  exp_b: 5,  ovf_b: 1'b0};
    vecs[5] = '{per: 5,  lvl: 1'b0, exp_a: 20, exp_b: 15, ovf_b: 1'b1};
    vecs[6] = '{per: 0,  lvl: 1'b0, exp_a: 0,  exp_b: 0,  ovf_b: 1'b0};
    vecs[7] = '{per: 25, lvl: 1'b0, exp_a: 4,  exp_b: 4,  ovf_b: 1'b0};

    // Reset state
    sig_per = 0;
    sig_lvl = 1'b1;
    repeat (3) @(posedge CLOCK);
    RESET = 1'b0;
    @(posedge CLOCK);
    check("reset busy_a", busy_a, 0);
    check("reset valid_a", valid_a, 0);
    check("reset freq_a", freq_a, 0);
    check("reset overflow_a", overflow_a, 0);
    check("reset busy_b", busy_b, 0);
    check("reset freq_b", freq_b, 0);
    repeat (10) @(posedge CLOCK);

    // Single measurements from the vector table
    for (int i = 0; i < 8; i++) begin
      sig_per = vecs[i].per;
      sig_lvl = vecs[i].lvl;
      repeat (12) @(posedge CLOCK);
      do_start(cyc);
      check($sformatf("v%0d busy at cycle 1", i), busy_a, 1);
      wait_valid(cyc);
      check($sformatf("v%0d valid latency", i), cyc, GATE + 1);
      check($sformatf("v%0d valid_b", i), valid_b, 1);
      check($sformatf("v%0d freq_a", i), freq_a, vecs[i].exp_a);
      check($sformatf("v%0d overflow_a", i), overflow_a, 0);
      check($sformatf("v%0d freq_b", i), freq_b, vecs[i].exp_b);
      check($sformatf("v%0d overflow_b", i), overflow_b, vecs[i].ovf_b);
      @(posedge CLOCK);
      check($sformatf("v%0d valid one cycle", i), valid_a, 0);
      check($sformatf("v%0d busy after done", i), busy_a, 0);
      check($sformatf("v%0d freq held", i), freq_a, vecs[i].exp_a);
    end

    // Continuous mode: pulses 101 cycles apart, one more after dropping the level
    sig_per = 10;
    repeat (12) @(posedge CLOCK);
    continuous = 1'b1;
    @(posedge CLOCK);
    cyc = 1;
    wait_valid(cyc);
    check("cont first latency", cyc, GATE + 1);
    check("cont first freq", freq_a, 10);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLOCK);
      cyc = 1;
      check($sformatf("cont busy between %0d", k), busy_a, 1);
      wait_valid(cyc);
      check($sformatf("cont spacing %0d", k), cyc, GATE + 1);
      check($sformatf("cont freq %0d", k), freq_a, 10);
    end
    @(posedge CLOCK);
    cyc = 1;
    advance_to(cyc, 50);
    continuous = 1'b0;
    wait_valid(cyc);
    check("cont last spacing", cyc, GATE + 1);
    check("cont last freq", freq_a, 10);
    @(posedge CLOCK);
    check("cont busy after drop", busy_a, 0);
    count_valid(150, cnt);
    check("cont no extra valid", cnt, 0);

    // Reset in the middle of a measurement
    do_start(cyc);
    advance_to(cyc, 50);
    RESET = 1'b1;
    @(posedge CLOCK);
    RESET = 1'b0;
    check("midreset busy", busy_a, 0);
    check("midreset freq", freq_a, 0);
    check("midreset valid", valid_a, 0);
    check("midreset overflow", overflow_a, 0);
    count_valid(150, cnt);
    check("midreset no valid", cnt, 0);
    do_start(cyc);
    wait_valid(cyc);
    check("after reset latency", cyc, GATE + 1);
    check("after reset freq", freq_a, 10);

    // Start pulsed mid-measurement is ignored
    repeat (5) @(posedge CLOCK);
    do_start(cyc);
    advance_to(cyc, 30);
    start = 1'b1;
    @(posedge CLOCK);
    start = 1'b0;
    cyc++;
    wait_valid(cyc);
    check("ignored start latency", cyc, GATE + 1);
    check("ignored start freq", freq_a, 10);
    @(posedge CLOCK);
    check("ignored start busy low", busy_a, 0);
    count_valid(150, cnt);
    check("ignored start no extra valid", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_freq_meter
